i2s_dac_tx: RTL and testbench
=============================

Name: i2s_dac_tx

Overview:
- Serial DAC transmitter at the far end of the mixer's DAC-side streaming interface.
- Accepts left and right 32-bit samples over independent valid/ready channels and buffers one sample per channel.
- Serializes samples as I2S (BCLK, LRCK, DACDAT) toward the codec, all on audio_clk.
- Replaces the vendor audio core's DAC FIFO path; it is the consumer of dacL/dacR streams.

Parameters:
- DATA_WIDTH, 32, sample width and bits per channel slot.
- BCLK_DIV, 4, audio_clk cycles per BCLK half-period (≥1).

Ports:
- audio_clk  in  1  system/audio clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request (driven from play control).
- dacL_valid_in  in  1  left sample valid.
- dacL_data_in  in  DATA_WIDTH  left sample.
- dacL_ready_out  out  1  left buffer can accept.
- dacR_valid_in  in  1  right sample valid.
- dacR_data_in  in  DATA_WIDTH  right sample.
- dacR_ready_out  out  1  right buffer can accept.
- bclk_out  out  1  I2S bit clock.
- lrck_out  out  1  I2S word select (0 = left, 1 = right).
- dacdat_out  out  1  I2S serial data, MSB first.
- underrun_out  out  1  one-cycle pulse when a slot starts with its buffer empty.
- underrun_count_out  out  16  saturating underrun counter.

Behaviour:
- Reset values:
  - all outputs 0, both buffers empty, state IDLE, divider/bit counters 0, shift register 0.
  - ready outputs return to 1 on the first cycle after reset deasserts.
- Buffers: one register plus full flag per channel.
  - X_ready_out = ~X_full, registered.
  - Transfer occurs when valid && ready on a rising edge; the flag sets the same edge.
  - Ready drops the following cycle.
  - Accepted independently of enable/state.
- Divider: div_cnt counts 0..BCLK_DIV-1 while not IDLE; bclk_out toggles at terminal count. BCLK period = 2*BCLK_DIV cycles.
- "Fall event" = the cycle in which bclk_out toggles 1→0. dacdat_out and lrck_out change only on fall events.
- Bit counter bit_cnt 0..DATA_WIDTH-1 advances on each fall event.
  - On wrap, lrck_out toggles (slot = DATA_WIDTH BCLKs, frame = 2*DATA_WIDTH BCLKs).
- I2S one-BCLK delay:
  - At the fall event where LRCK toggles, dacdat_out shows the previous slot's LSB.
  - The new slot's MSB appears on the next fall event.
  - The shift register loads at the LRCK toggle.
- Slot load:
  - If the channel buffer is full, load it and clear full in the same cycle. A write cannot land that cycle since ready was 0.
  - If empty, load zeros, pulse underrun_out and increment underrun_count_out, saturating at 0xFFFF.
- FSM:
  - IDLE → RUN when enable=1. First cycle begins a left slot with bclk=0, lrck=0; the left load occurs then.
  - RUN → DRAIN when enable=0.
  - DRAIN completes the current frame through the right slot LSB.
  - DRAIN → IDLE at the fall event ending the right slot; bclk/lrck/dacdat are then forced to 0.
  - In DRAIN, enable=1 returns to RUN with no glitch.
- In IDLE the counters hold 0 and no underruns are counted.
- Reset mid-frame: immediate return to reset values; buffered samples are discarded.

Test Plan:
- Reset/idle: assert reset 2 cycles, enable=0 → all outputs 0; ready both 1 one cycle after reset release; bclk static.
- Single frame, BCLK_DIV=4:
  - Write L=0xA5A50001, R=0x80000000, then enable.
  - Expect BCLK period 8 cycles; ready low after each write.
  - Expect the left slot to shift out A5A50001 MSB-first starting one BCLK after LRCK=0.
  - Expect the right slot to shift out 1 then 31 zeros, with LRCK high for 32 BCLKs.
  - No underrun.
- Underrun: enable with both buffers empty for 2 frames → 4 underrun pulses, count=4, dacdat constant 0.
- Backpressure:
  - Hold dacL_valid_in=1 with changing data.
  - Only the value present at each ready=1 edge is transmitted.
  - Exactly one left acceptance per frame, one cycle after that frame's left load.
- Drain:
  - Drop enable mid-left-slot → left and right slots complete, then IDLE with outputs 0.
  - Re-raise enable during DRAIN → continues next frame seamlessly.
- Reset mid-right-slot → next cycle all outputs 0, buffers empty, count 0.

Source files
------------

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: buffers one left and one right sample and serializes
// them MSB-first with the standard one-BCLK data delay after each LRCK edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | bus parked at 0, counters held at 0, buffers still accept
// ST_RUN   | frames stream continuously while enable is high
// ST_DRAIN | enable dropped; finish the current frame, then park
module i2s_dac_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int BCLK_DIV   = 4
) (
   input  logic                  audio_clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  dacL_valid_in,
   input  logic [DATA_WIDTH-1:0] dacL_data_in,
   output logic                  dacL_ready_out,
   input  logic                  dacR_valid_in,
   input  logic [DATA_WIDTH-1:0] dacR_data_in,
   output logic                  dacR_ready_out,
   output logic                  bclk_out,
   output logic                  lrck_out,
   output logic                  dacdat_out,
   output logic                  underrun_out,
   output logic [15:0]           underrun_count_out
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_cnt;
   logic [BIT_W-1:0]      bit_cnt;
   logic [DATA_WIDTH-1:0] shift_q, buf_l, buf_r, load_word;
   logic                  full_l, full_r, full_l_d, full_r_d;
   logic                  wr_l, wr_r, div_tc, fall_evt, slot_end;
   logic                  start, go_idle, load_l, load_r, underrun;

   always_comb begin
      div_tc   = (div_cnt == DIV_LAST);
      fall_evt = (state_q != ST_IDLE) && div_tc && bclk_out;
      slot_end = fall_evt && (bit_cnt == BIT_LAST);
      start    = (state_q == ST_IDLE) && enable;
      go_idle  = (state_q == ST_DRAIN) && !enable && slot_end && lrck_out;
      load_l   = start || (slot_end && lrck_out && !go_idle);
      load_r   = slot_end && !lrck_out;
      wr_l     = dacL_valid_in && dacL_ready_out;
      wr_r     = dacR_valid_in && dacR_ready_out;
      full_l_d = wr_l || (full_l && !load_l);
      full_r_d = wr_r || (full_r && !load_r);
      // An empty buffer at slot start transmits silence.
      load_word = load_r ? (full_r ? buf_r : '0) : (full_l ? buf_l : '0);
      underrun  = (load_l && !full_l) || (load_r && !full_r);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (enable) state_d = ST_RUN;
         ST_RUN:   if (!enable) state_d = ST_DRAIN;
         ST_DRAIN: begin
            if (enable)
               state_d = ST_RUN;
            else if (slot_end && lrck_out)
               state_d = ST_IDLE;
         end
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge audio_clk) begin
      if (reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge audio_clk) begin
      if (reset) begin
         full_l             <= 1'b0;
         full_r             <= 1'b0;
         buf_l              <= '0;
         buf_r              <= '0;
         dacL_ready_out     <= 1'b0;
         dacR_ready_out     <= 1'b0;
         underrun_out       <= 1'b0;
         underrun_count_out <= '0;
         div_cnt            <= '0;
         bit_cnt            <= '0;
         shift_q            <= '0;
         bclk_out           <= 1'b0;
         lrck_out           <= 1'b0;
         dacdat_out         <= 1'b0;
      end else begin
         full_l         <= full_l_d;
         full_r         <= full_r_d;
         dacL_ready_out <= !full_l_d;
         dacR_ready_out <= !full_r_d;
         if (wr_l) buf_l <= dacL_data_in;
         if (wr_r) buf_r <= dacR_data_in;

         underrun_out <= underrun;
         if (underrun && (underrun_count_out != 16'hFFFF))
            underrun_count_out <= underrun_count_out + 16'd1;

         if (state_q == ST_IDLE || go_idle) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            bclk_out   <= 1'b0;
            lrck_out   <= 1'b0;
            dacdat_out <= 1'b0;
            shift_q    <= start ? load_word : '0;
         end else begin
            div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
            if (div_tc) bclk_out <= ~bclk_out;
            // Data and word select only move on BCLK falling edges.
            if (fall_evt) begin
               dacdat_out <= shift_q[DATA_WIDTH-1];
               if (slot_end) begin
                  bit_cnt  <= '0;
                  lrck_out <= ~lrck_out;
                  shift_q  <= load_word;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                  shift_q <= shift_q << 1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Bench for i2s_dac_tx: expected waveforms are computed from BCLK/slot
// arithmetic over a per-slot sample table.
module tb_i2s_dac_tx;

   localparam int W     = 32;
   localparam int BD    = 4;
   localparam int SLOT  = W * 2 * BD;
   localparam int FRAME = 2 * SLOT;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic          l_valid = 1'b0, r_valid = 1'b0;
   logic [W-1:0]  l_data = '0, r_data = '0;
   logic          l_ready, r_ready, bclk, lrck, dacdat, underrun;
   logic [15:0]   ucount;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_l [0:3];
   logic [W-1:0] exp_r [0:3];
   bit           und_l [0:3];
   bit           und_r [0:3];

   i2s_dac_tx #(.DATA_WIDTH(W), .BCLK_DIV(BD)) dut (
      .audio_clk          (clk),
      .reset              (reset),
      .enable             (enable),
      .dacL_valid_in      (l_valid),
      .dacL_data_in       (l_data),
      .dacL_ready_out     (l_ready),
      .dacR_valid_in      (r_valid),
      .dacR_data_in       (r_data),
      .dacR_ready_out     (r_ready),
      .bclk_out           (bclk),
      .lrck_out           (lrck),
      .dacdat_out         (dacdat),
      .underrun_out       (underrun),
      .underrun_count_out (ucount)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; enable = 1'b0; l_valid = 1'b0; r_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      step();
   endtask

   function automatic logic [W-1:0] slot_word(input int sp);
      return (sp % 2 == 1) ? exp_r[sp/2] : exp_l[sp/2];
   endfunction

   // Runs n frames from IDLE, checking the bus every cycle. In bp mode both
   // valids stay high with fresh random data each cycle, so the bench records
   // which value sits on the bus one cycle after each slot load.
   task automatic run(input int n, input bit bp, input int drop_t,
                      input int rise_t, input int drop2_t);
      logic [W-1:0] lv, rv, w;
      int b, p;
      logic e_bclk, e_lrck, e_dat, e_und;
      if (bp) begin
         exp_l[0] = $urandom; exp_r[0] = $urandom;
         und_l[0] = 1'b0;     und_r[0] = 1'b0;
         l_valid = 1'b1; r_valid = 1'b1;
         l_data = exp_l[0]; r_data = exp_r[0];
         step();
         l_data = $urandom; r_data = $urandom;
      end
      enable = 1'b1;
      step();
      for (int t = 0; t < FRAME * n + 4; t++) begin
         if (t < FRAME * n) begin
            b      = t / (2 * BD);
            e_bclk = ((t / BD) % 2) == 1;
            e_lrck = ((b / W) % 2) == 1;
            if (b == 0) begin
               e_dat = 1'b0;
            end else begin
               p     = b - 1;
               w     = slot_word(p / W);
               e_dat = w[W - 1 - (p % W)];
            end
            if (t % SLOT == 0)
               e_und = ((t / SLOT) % 2 == 1) ? und_r[t/FRAME] : und_l[t/FRAME];
            else
               e_und = 1'b0;
         end else begin
            e_bclk = 1'b0; e_lrck = 1'b0; e_dat = 1'b0; e_und = 1'b0;
         end
         chk("bclk", bclk, e_bclk);
         chk("lrck", lrck, e_lrck);
         chk("dacdat", dacdat, e_dat);
         chk("underrun", underrun, e_und);
         if (bp && t < FRAME * n) begin
            chk("l_ready", l_ready, (t % FRAME) == 0);
            chk("r_ready", r_ready, (t % FRAME) == SLOT);
         end
         enable = (t < drop_t) || (t >= rise_t && t < drop2_t);
         if (bp) begin
            lv = $urandom; rv = $urandom;
            l_data = lv; r_data = rv;
            if (t % FRAME == 0 && t / FRAME + 1 < 4) begin
               exp_l[t/FRAME + 1] = lv; und_l[t/FRAME + 1] = 1'b0;
            end
            if (t % FRAME == SLOT && t / FRAME + 1 < 4) begin
               exp_r[t/FRAME + 1] = rv; und_r[t/FRAME + 1] = 1'b0;
            end
         end
         step();
      end
      l_valid = 1'b0; r_valid = 1'b0; enable = 1'b0;
   endtask

   initial begin
      // Reset and idle
      step(); step();
      chk("rst_bclk", bclk, 0);
      chk("rst_lrck", lrck, 0);
      chk("rst_dacdat", dacdat, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_count", ucount, 0);
      chk("rst_l_ready", l_ready, 0);
      chk("rst_r_ready", r_ready, 0);
      reset = 1'b0;
      step();
      chk("rel_l_ready", l_ready, 1);
      chk("rel_r_ready", r_ready, 1);
      for (int i = 0; i < 6; i++) begin
         chk("idle_bclk", bclk, 0);
         step();
      end

      // Single frame with known samples
      l_valid = 1'b1; l_data = 32'hA5A5_0001;
      step();
      l_valid = 1'b0;
      chk("wr_l_ready_low", l_ready, 0);
      r_valid = 1'b1; r_data = 32'h8000_0000;
      step();
      r_valid = 1'b0;
      chk("wr_r_ready_low", r_ready, 0);
      for (int i = 0; i < 4; i++) begin
         exp_l[i] = '0; exp_r[i] = '0; und_l[i] = 1'b1; und_r[i] = 1'b1;
      end
      exp_l[0] = 32'hA5A5_0001; und_l[0] = 1'b0;
      exp_r[0] = 32'h8000_0000; und_r[0] = 1'b0;
      run(1, 1'b0, 100, 0, 0);
      chk("single_count", ucount, 0);

      // Underrun: two frames with empty buffers
      do_reset();
      for (int i = 0; i < 4; i++) begin
         exp_l[i] = '0; exp_r[i] = '0; und_l[i] = 1'b1; und_r[i] = 1'b1;
      end
      run(2, 1'b0, FRAME + 100, 0, 0);
      chk("underrun_count", ucount, 4);

      // Backpressure with continuously changing data
      do_reset();
      run(2, 1'b1, FRAME + 100, 0, 0);
      chk("bp_count", ucount, 0);

      // Drain with enable re-raised mid-drain
      do_reset();
      run(2, 1'b1, 100, 300, FRAME + 100);
      chk("reraise_count", ucount, 0);

      // Reset during the right slot
      do_reset();
      l_valid = 1'b1; l_data = $urandom;
      step();
      l_valid = 1'b0;
      enable = 1'b1;
      step();
      for (int t = 0; t < 300; t++) begin
         l_valid = (t == 10);
         l_data  = $urandom;
         step();
      end
      l_valid = 1'b0;
      chk("pre_rst_count", ucount, 1);
      reset = 1'b1; enable = 1'b0;
      step();
      chk("mid_rst_bclk", bclk, 0);
      chk("mid_rst_lrck", lrck, 0);
      chk("mid_rst_dacdat", dacdat, 0);
      chk("mid_rst_count", ucount, 0);
      reset = 1'b0;
      step();
      chk("mid_rel_l_ready", l_ready, 1);
      chk("mid_rel_r_ready", r_ready, 1);
      enable = 1'b1;
      step();
      chk("mid_rel_underrun", underrun, 1);
      enable = 1'b0;
      step();
      chk("mid_rel_count", ucount, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
